// File: rtl/mseq_pkg.sv
// Purpose: shared state encoding and default code sizing for the M-sequence scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mseq_pkg;

    localparam int MSEQ_N      = 63;
    localparam int MSEQ_LENGTH = $clog2(MSEQ_N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } mseq_state_t;

endpackage

// File: rtl/mseq_rr_arbiter.sv
// Purpose: round-robin pick of one requester, searching from last_owner+1 with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
module mseq_rr_arbiter
    import mseq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] idx;

    // walk the requesters once, starting just after the previous owner; first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_owner) + i) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mseq_code_scheduler.sv
// Purpose: time-share one M-sequence generator among NREQ requesters (optional watchdog: MSEQ_SCHED_TIMEOUT_EN).
// Latency: request to gen_valid_o/gen_code_o is one cycle; one DONE cycle with valid low separates bursts.
// Backpressure: no grant while gen_ready_i is low in IDLE; a burst ends when gen_ready_i returns high.
module mseq_code_scheduler
    import mseq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int N       = MSEQ_N,
    parameter int LENGTH  = $clog2(N),
    parameter int TIMEOUT = 1024
) (
    input  logic                   clkin,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*LENGTH-1:0] code_i,
    output logic [NREQ-1:0]        grant_o,
    output logic [NREQ-1:0]        done_o,
    output logic                   busy_o,
    output logic                   gen_valid_o,
    output logic [LENGTH-1:0]      gen_code_o,
    input  logic                   gen_ready_i,
    output logic                   err_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    mseq_state_t       state, state_d;
    logic [NREQ-1:0]   grant_d, done_d, arb_gnt;
    logic [LENGTH-1:0] code_d;
    logic              valid_d, err_d, arb_any, finish, tmo_hit;
    logic [IW-1:0]     arb_idx, owner_idx, owner_d, last_owner, last_d;
    logic              unused_cfg;

    assign unused_cfg = (N > 0) && (TIMEOUT > 0);

    mseq_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req        (req_i),
        .last_owner (last_owner),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

`ifdef MSEQ_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // burst watchdog: zero while idle (so zero on entering LOAD), counts LOAD/RUN cycles
    always_ff @(posedge clkin) begin
        if (!rstn || state == ST_IDLE) begin
            cnt <= '0;
        end else if (state == ST_LOAD || state == ST_RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tmo_hit = (cnt == CW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign busy_o = (state != ST_IDLE);

    // next state and next output values; outputs hold unless a transition changes them
    always_comb begin
        state_d = state;
        grant_d = grant_o;
        done_d  = '0;
        err_d   = 1'b0;
        valid_d = gen_valid_o;
        code_d  = gen_code_o;
        owner_d = owner_idx;
        last_d  = last_owner;
        finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any && gen_ready_i) begin
                    state_d = ST_LOAD;
                    grant_d = arb_gnt;
                    code_d  = code_i[int'(arb_idx)*LENGTH +: LENGTH];
                    valid_d = 1'b1;
                    owner_d = arb_idx;
                end
            end
            ST_LOAD: begin
                if (!gen_ready_i) begin
                    state_d = ST_RUN;
                end else if (tmo_hit) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (gen_ready_i) begin
                    finish = 1'b1;
                    done_d = grant_o;
                end else if (tmo_hit) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // every way into DONE drops the generator and hands priority onwards
        if (finish) begin
            state_d = ST_DONE;
            grant_d = '0;
            valid_d = 1'b0;
            last_d  = owner_idx;
        end
    end

    // state and registered outputs; reset parks requester NREQ-1 as last owner so 0 goes first
    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            grant_o     <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            gen_valid_o <= 1'b0;
            gen_code_o  <= '0;
            owner_idx   <= '0;
            last_owner  <= IW'(NREQ - 1);
        end else begin
            state       <= state_d;
            grant_o     <= grant_d;
            done_o      <= done_d;
            err_o       <= err_d;
            gen_valid_o <= valid_d;
            gen_code_o  <= code_d;
            owner_idx   <= owner_d;
            last_owner  <= last_d;
        end
    end

endmodule
